// File: rtl/stroke_scheduler_if.sv
// ---------------------------------------------------------------------------
// stroke_scheduler_if
//   Bundles every handshake/bus signal of the stroke scheduler so the block
//   can be wired to its environment with a single port.
//
//   Signal groups:
//     layer control : i_start, i_radius, i_threshold, o_busy, o_done, o_stroke_cnt
//     error query   : o_err_req, o_err_x, o_err_y, i_err_valid, i_err
//     stroke gen    : o_stk_start, o_stk_x0, o_stk_y0, o_stk_r, o_stk_abort,
//                     i_pt_valid, i_pt_x, i_pt_y, i_stk_finish, o_pt_ready
//     painter       : o_paint_valid, o_paint_x, o_paint_y, o_paint_r, i_paint_ready
//
//   Modports:
//     master : the scheduler itself (drives the o_* signals)
//     slave  : the surrounding environment (drives the i_* signals)
// ---------------------------------------------------------------------------
interface stroke_scheduler_if;
    // layer control
    logic        i_start;
    logic [3:0]  i_radius;
    logic [15:0] i_threshold;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_stroke_cnt;
    // error query
    logic        o_err_req;
    logic [9:0]  o_err_x;
    logic [9:0]  o_err_y;
    logic        i_err_valid;
    logic [15:0] i_err;
    // stroke generator
    logic        o_stk_start;
    logic [9:0]  o_stk_x0;
    logic [9:0]  o_stk_y0;
    logic [3:0]  o_stk_r;
    logic        o_stk_abort;
    logic        i_pt_valid;
    logic [9:0]  i_pt_x;
    logic [9:0]  i_pt_y;
    logic        i_stk_finish;
    logic        o_pt_ready;
    // painter
    logic        o_paint_valid;
    logic [9:0]  o_paint_x;
    logic [9:0]  o_paint_y;
    logic [3:0]  o_paint_r;
    logic        i_paint_ready;

    modport master (
        input  i_start, i_radius, i_threshold,
        input  i_err_valid, i_err,
        input  i_pt_valid, i_pt_x, i_pt_y, i_stk_finish,
        input  i_paint_ready,
        output o_busy, o_done, o_stroke_cnt,
        output o_err_req, o_err_x, o_err_y,
        output o_stk_start, o_stk_x0, o_stk_y0, o_stk_r, o_stk_abort, o_pt_ready,
        output o_paint_valid, o_paint_x, o_paint_y, o_paint_r
    );

    modport slave (
        output i_start, i_radius, i_threshold,
        output i_err_valid, i_err,
        output i_pt_valid, i_pt_x, i_pt_y, i_stk_finish,
        output i_paint_ready,
        input  o_busy, o_done, o_stroke_cnt,
        input  o_err_req, o_err_x, o_err_y,
        input  o_stk_start, o_stk_x0, o_stk_y0, o_stk_r, o_stk_abort, o_pt_ready,
        input  o_paint_valid, o_paint_x, o_paint_y, o_paint_r
    );
endinterface

// File: rtl/stroke_scheduler.sv
// ---------------------------------------------------------------------------
// stroke_scheduler
//   Runs one painterly layer pass: walks every GRIDxGRID cell in raster order
//   (x fastest), queries the canvas/reference error at the cell centre, and
//   when the error is strictly above the latched threshold launches the
//   stroke generator there. Generated points are forwarded to the painter
//   combinationally with back-pressure; a stroke is truncated after MAX_LEN
//   accepted points.
//
//   Ports:
//     i_clk : clock
//     i_rst : synchronous active-high reset (aborts a pass, no o_done)
//     bus   : stroke_scheduler_if.master - layer control, error query,
//             stroke generator and painter handshakes
//
//   Parameters:
//     IMG_W, IMG_H : image size in pixels, multiples of GRID
//     GRID         : cell size, power of two >= 2
//     MAX_LEN      : max accepted points per stroke (1..1023)
// ---------------------------------------------------------------------------
module stroke_scheduler #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int GRID    = 8,
    parameter int MAX_LEN = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    stroke_scheduler_if.master bus
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CX_N = IMG_W / GRID;
    localparam int CY_N = IMG_H / GRID;
    localparam int CXW  = (CX_N > 1) ? $clog2(CX_N) : 1;
    localparam int CYW  = (CY_N > 1) ? $clog2(CY_N) : 1;
    localparam int PW   = $clog2(MAX_LEN + 1);

    localparam logic [CXW-1:0] CX_LAST = CXW'(CX_N - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(CY_N - 1);
    localparam logic [PW-1:0]  PT_LAST = PW'(MAX_LEN - 1);
    localparam logic [9:0]     HALF    = 10'(GRID / 2);
    localparam logic [9:0]     STEP    = 10'(GRID);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_QUERY  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_STROKE = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]     state_reg;
    logic [2:0]     state_next;

    logic [3:0]     radius_reg;
    logic [15:0]    threshold_reg;
    logic [CXW-1:0] cx_reg;
    logic [CYW-1:0] cy_reg;
    // Cell centre is tracked incrementally alongside the cell indices so no
    // multiplier is needed; it also gives all-zero coordinates after reset.
    logic [9:0]     cen_x_reg;
    logic [9:0]     cen_y_reg;
    logic [PW-1:0]  pt_cnt_reg;
    logic [15:0]    stroke_cnt_reg;

    logic           in_stroke;
    logic           pt_accept;
    logic           pt_last;
    logic           last_cell;
    logic [9:0]     paint_x;
    logic [9:0]     paint_y;

    assign in_stroke = (state_reg == S_STROKE);
    assign pt_accept = in_stroke & bus.i_pt_valid & bus.i_paint_ready;
    assign pt_last   = (pt_cnt_reg == PT_LAST);
    assign last_cell = (cx_reg == CX_LAST) && (cy_reg == CY_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_next = S_QUERY;
                end
            end
            S_QUERY: begin
                if (bus.i_err_valid) begin
                    state_next = (bus.i_err > threshold_reg) ? S_LAUNCH : S_NEXT;
                end
            end
            S_LAUNCH: begin
                state_next = S_STROKE;
            end
            S_STROKE: begin
                // A finishing generator wins over truncation: the stroke ended
                // on its own, so no abort is signalled.
                if (bus.i_stk_finish) begin
                    state_next = S_NEXT;
                end else if (pt_accept && pt_last) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                state_next = S_NEXT;
            end
            S_NEXT: begin
                state_next = last_cell ? S_DONE : S_QUERY;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= S_IDLE;
            radius_reg     <= '0;
            threshold_reg  <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            cen_x_reg      <= '0;
            cen_y_reg      <= '0;
            pt_cnt_reg     <= '0;
            stroke_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (bus.i_start) begin
                        radius_reg     <= bus.i_radius;
                        threshold_reg  <= bus.i_threshold;
                        cx_reg         <= '0;
                        cy_reg         <= '0;
                        cen_x_reg      <= HALF;
                        cen_y_reg      <= HALF;
                        pt_cnt_reg     <= '0;
                        stroke_cnt_reg <= '0;
                    end
                end
                S_LAUNCH: begin
                    pt_cnt_reg <= '0;
                    if (stroke_cnt_reg != 16'hFFFF) begin
                        stroke_cnt_reg <= stroke_cnt_reg + 16'd1;
                    end
                end
                S_STROKE: begin
                    if (pt_accept) begin
                        pt_cnt_reg <= pt_cnt_reg + 1'b1;
                    end
                end
                S_NEXT: begin
                    // On the last cell the indices are left alone so the final
                    // centre stays visible after the pass.
                    if (!last_cell) begin
                        if (cx_reg == CX_LAST) begin
                            cx_reg    <= '0;
                            cen_x_reg <= HALF;
                            cy_reg    <= cy_reg + 1'b1;
                            cen_y_reg <= cen_y_reg + STEP;
                        end else begin
                            cx_reg    <= cx_reg + 1'b1;
                            cen_x_reg <= cen_x_reg + STEP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Painter coordinates: pass-through during a stroke, forced to zero
    // otherwise so idle/reset outputs are clean.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_paint_gate
            assign paint_x[gi] = in_stroke & bus.i_pt_x[gi];
            assign paint_y[gi] = in_stroke & bus.i_pt_y[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.o_done        = (state_reg == S_DONE);
    assign bus.o_stroke_cnt  = stroke_cnt_reg;

    assign bus.o_err_req     = (state_reg == S_QUERY);
    assign bus.o_err_x       = cen_x_reg;
    assign bus.o_err_y       = cen_y_reg;

    assign bus.o_stk_start   = (state_reg == S_LAUNCH);
    assign bus.o_stk_x0      = cen_x_reg;
    assign bus.o_stk_y0      = cen_y_reg;
    assign bus.o_stk_r       = radius_reg;
    assign bus.o_stk_abort   = (state_reg == S_ABORT);
    assign bus.o_pt_ready    = in_stroke & bus.i_paint_ready;

    assign bus.o_paint_valid = in_stroke & bus.i_pt_valid;
    assign bus.o_paint_x     = paint_x;
    assign bus.o_paint_y     = paint_y;
    assign bus.o_paint_r     = radius_reg;

endmodule

// File: tb/tb_stroke_scheduler.sv
// ---------------------------------------------------------------------------
// tb_stroke_scheduler
//   Directed bench for stroke_scheduler with a 32x16 image, 8-pixel cells
//   (4x2 grid) and MAX_LEN=4. Query passes are driven from a vector table;
//   strokes, truncation, back-pressure and reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_stroke_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stroke_scheduler_if bus();

    stroke_scheduler #(
        .IMG_W  (32),
        .IMG_H  (16),
        .GRID   (8),
        .MAX_LEN(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [3:0] cur_r;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] err;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic        launch;
    } qvec_t;

    qvec_t tbl[16];
    int    exp_cx[8] = '{4, 12, 20, 28, 4, 12, 20, 28};
    int    exp_cy[8] = '{4, 4, 4, 4, 12, 12, 12, 12};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_start       = 1'b0;
        bus.i_radius      = '0;
        bus.i_threshold   = '0;
        bus.i_err_valid   = 1'b0;
        bus.i_err         = '0;
        bus.i_pt_valid    = 1'b0;
        bus.i_pt_x        = '0;
        bus.i_pt_y        = '0;
        bus.i_stk_finish  = 1'b0;
        bus.i_paint_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_busy"},      bus.o_busy, 0);
        check({p, "_done"},      bus.o_done, 0);
        check({p, "_err_req"},   bus.o_err_req, 0);
        check({p, "_err_x"},     bus.o_err_x, 0);
        check({p, "_err_y"},     bus.o_err_y, 0);
        check({p, "_stk_start"}, bus.o_stk_start, 0);
        check({p, "_stk_x0"},    bus.o_stk_x0, 0);
        check({p, "_stk_r"},     bus.o_stk_r, 0);
        check({p, "_stk_abort"}, bus.o_stk_abort, 0);
        check({p, "_pt_ready"},  bus.o_pt_ready, 0);
        check({p, "_pvalid"},    bus.o_paint_valid, 0);
        check({p, "_paint_x"},   bus.o_paint_x, 0);
        check({p, "_paint_r"},   bus.o_paint_r, 0);
        check({p, "_cnt"},       bus.o_stroke_cnt, 0);
    endtask

    task automatic start_pass(input logic [3:0] r, input logic [15:0] thr, output int t0);
        bus.i_start     = 1'b1;
        bus.i_radius    = r;
        bus.i_threshold = thr;
        cur_r           = r;
        step();
        bus.i_start     = 1'b0;
        bus.i_radius    = '0;
        bus.i_threshold = '0;
        t0              = cyc;
        $display("start pass r=%0d thr=%0d", r, thr);
        check("busy_after_start", bus.o_busy, 1);
    endtask

    // Waits (bounded) for a query, checks its centre, optionally holds off
    // the answer for 'delay' cycles, answers, and checks the launch decision.
    task automatic serve_query(input string tag, input logic [15:0] err, input logic [9:0] ex,
                               input logic [9:0] ey, input logic launch, input int delay);
        int n = 0;
        while (!bus.o_err_req && n < 20) begin
            step();
            n++;
        end
        if (!bus.o_err_req) begin
            check({tag, "_req_timeout"}, 0, 1);
            return;
        end
        for (int d = 0; d < delay; d++) begin
            step();
            check({tag, "_req_held"}, bus.o_err_req, 1);
        end
        check({tag, "_qx"}, bus.o_err_x, ex);
        check({tag, "_qy"}, bus.o_err_y, ey);
        $display("query %s at (%0d,%0d) err=%0d", tag, bus.o_err_x, bus.o_err_y, err);
        bus.i_err_valid = 1'b1;
        bus.i_err       = err;
        step();
        bus.i_err_valid = 1'b0;
        bus.i_err       = 16'hFFFF;
        check({tag, "_stk_start"}, bus.o_stk_start, launch);
        if (launch) begin
            check({tag, "_x0"}, bus.o_stk_x0, ex);
            check({tag, "_y0"}, bus.o_stk_y0, ey);
            check({tag, "_r"},  bus.o_stk_r, cur_r);
            $display("launch %s at (%0d,%0d) r=%0d", tag, bus.o_stk_x0, bus.o_stk_y0, bus.o_stk_r);
            step();
            check({tag, "_start_pulse"}, bus.o_stk_start, 0);
        end
    endtask

    // Three points, finish together with the third, painter always ready.
    task automatic stroke_basic();
        bus.i_paint_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_pt_valid   = 1'b1;
            bus.i_pt_x       = 10'(100 + k);
            bus.i_pt_y       = 10'(200 + k);
            bus.i_stk_finish = (k == 2);
            #1;
            check("basic_ready",  bus.o_pt_ready, 1);
            check("basic_pvalid", bus.o_paint_valid, 1);
            check("basic_px",     bus.o_paint_x, 100 + k);
            check("basic_py",     bus.o_paint_y, 200 + k);
            check("basic_pr",     bus.o_paint_r, cur_r);
            $display("paint (%0d,%0d)", bus.o_paint_x, bus.o_paint_y);
            step();
        end
        bus.i_pt_valid   = 1'b0;
        bus.i_stk_finish = 1'b0;
        #1;
        check("basic_end_ready", bus.o_pt_ready, 0);
        check("basic_end_abort", bus.o_stk_abort, 0);
        bus.i_paint_ready = 1'b0;
    endtask

    // Painter ready toggles 1,0,1,0,...; three points, finish with the last.
    task automatic stroke_toggle();
        int  j = 0;
        logic rdy;
        for (int c = 0; c < 12 && j < 3; c++) begin
            rdy               = ((c % 2) == 0);
            bus.i_paint_ready = rdy;
            bus.i_pt_valid    = 1'b1;
            bus.i_pt_x        = 10'(400 + j);
            bus.i_pt_y        = 10'(60 + j);
            bus.i_stk_finish  = (j == 2) && rdy;
            #1;
            check("tog_mirror", bus.o_pt_ready, rdy);
            if (bus.o_paint_valid && bus.i_paint_ready) begin
                check("tog_order", bus.o_paint_x, 400 + j);
                $display("paint (%0d,%0d)", bus.o_paint_x, bus.o_paint_y);
                j++;
            end
            step();
        end
        bus.i_pt_valid    = 1'b0;
        bus.i_stk_finish  = 1'b0;
        bus.i_paint_ready = 1'b1;
        #1;
        check("tog_count", j, 3);
        check("tog_end_ready", bus.o_pt_ready, 0);
        check("tog_end_abort", bus.o_stk_abort, 0);
        bus.i_paint_ready = 1'b0;
    endtask

    // Six points streamed without finish: only four reach the painter.
    task automatic stroke_abort();
        int acc = 0;
        bus.i_paint_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.i_pt_valid = 1'b1;
            bus.i_pt_x     = 10'(300 + k);
            bus.i_pt_y     = 10'd50;
            #1;
            check("abort_ready", bus.o_pt_ready, (k < 4));
            check("abort_pulse", bus.o_stk_abort, (k == 4));
            if (k < 4) check("abort_px", bus.o_paint_x, 300 + k);
            if (bus.o_paint_valid && bus.i_paint_ready) begin
                acc++;
                $display("paint (%0d,%0d)", bus.o_paint_x, bus.o_paint_y);
            end
            step();
        end
        bus.i_pt_valid    = 1'b0;
        bus.i_paint_ready = 1'b0;
        check("abort_accepted", acc, 4);
        check("abort_next_req", bus.o_err_req, 1);
        check("abort_next_x",   bus.o_err_x, 28);
    endtask

    // Finish with a point while the painter is stalled: the point is dropped.
    task automatic stroke_drop();
        bus.i_pt_valid    = 1'b1;
        bus.i_pt_x        = 10'd500;
        bus.i_pt_y        = 10'd70;
        bus.i_paint_ready = 1'b0;
        bus.i_stk_finish  = 1'b1;
        #1;
        check("drop_pvalid", bus.o_paint_valid, 1);
        check("drop_ready",  bus.o_pt_ready, 0);
        step();
        bus.i_stk_finish  = 1'b0;
        bus.i_paint_ready = 1'b1;
        #1;
        check("drop_next_ready",  bus.o_pt_ready, 0);
        check("drop_next_pvalid", bus.o_paint_valid, 0);
        bus.i_pt_valid    = 1'b0;
        bus.i_paint_ready = 1'b0;
        step();
        check("drop_next_query", bus.o_err_req, 1);
    endtask

    task automatic wait_done(input int t0, input int exp_cycles, input int exp_cnt);
        int n = 0;
        while (!bus.o_done && n < 200) begin
            step();
            n++;
        end
        if (!bus.o_done) begin
            check("done_timeout", 0, 1);
            return;
        end
        $display("pass done after %0d cycles strokes=%0d", cyc - t0, bus.o_stroke_cnt);
        if (exp_cycles >= 0) check("done_latency", cyc - t0, exp_cycles);
        check("done_busy", bus.o_busy, 0);
        check("done_cnt",  bus.o_stroke_cnt, exp_cnt);
        step();
        check("done_pulse", bus.o_done, 0);
        check("cnt_held",   bus.o_stroke_cnt, exp_cnt);
    endtask

    task automatic run_table_pass(input int base, input logic [15:0] thr, input logic [3:0] r,
                                  input int exp_cycles, input int exp_cnt);
        int t0;
        start_pass(r, thr, t0);
        for (int i = 0; i < 8; i++) begin
            serve_query($sformatf("t%0d", base + i), tbl[base + i].err, tbl[base + i].ex,
                        tbl[base + i].ey, tbl[base + i].launch, 0);
            if (tbl[base + i].launch) stroke_basic();
        end
        wait_done(t0, exp_cycles, exp_cnt);
    endtask

    initial begin
        int t0;

        // Pass A (0..7): all errors 0. Pass B (8..15): only cell 2 above 10.
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{16'd0, 10'(exp_cx[i]), 10'(exp_cy[i]), 1'b0};
            tbl[8 + i] = '{(i == 2) ? 16'd11 : 16'd10, 10'(exp_cx[i]), 10'(exp_cy[i]), (i == 2)};
        end

        idle_inputs();
        cur_r = '0;
        rst   = 1'b1;
        step();
        step();
        check_all_zero("rst");
        rst = 1'b0;
        step();

        run_table_pass(0, 16'd10, 4'd3, 16, 0);
        run_table_pass(8, 16'd10, 4'd6, 20, 1);

        // Back-pressure, finish-with-point, truncation, delayed answer, drop.
        start_pass(4'd5, 16'd100, t0);
        serve_query("p3c0", 16'd101, 10'd4,  10'd4,  1'b1, 0);
        stroke_toggle();
        serve_query("p3c1", 16'd100, 10'd12, 10'd4,  1'b0, 0);
        serve_query("p3c2", 16'd200, 10'd20, 10'd4,  1'b1, 0);
        stroke_abort();
        serve_query("p3c3", 16'd0,   10'd28, 10'd4,  1'b0, 3);
        serve_query("p3c4", 16'd150, 10'd4,  10'd12, 1'b1, 0);
        stroke_drop();
        serve_query("p3c5", 16'd0,   10'd12, 10'd12, 1'b0, 0);
        serve_query("p3c6", 16'd0,   10'd20, 10'd12, 1'b0, 0);
        serve_query("p3c7", 16'd0,   10'd28, 10'd12, 1'b0, 0);
        wait_done(t0, -1, 3);

        // Ignored restart mid-pass, then reset during a stroke.
        start_pass(4'd7, 16'd0, t0);
        bus.i_start     = 1'b1;
        bus.i_radius    = 4'd2;
        bus.i_threshold = 16'hFFFF;
        step();
        bus.i_start     = 1'b0;
        bus.i_radius    = '0;
        bus.i_threshold = '0;
        check("ign_start_busy", bus.o_busy, 1);
        check("ign_start_req",  bus.o_err_req, 1);
        serve_query("p4c0", 16'd1, 10'd4, 10'd4, 1'b1, 0);
        bus.i_pt_valid    = 1'b1;
        bus.i_pt_x        = 10'd9;
        bus.i_pt_y        = 10'd9;
        bus.i_paint_ready = 1'b1;
        #1;
        check("pre_rst_pvalid", bus.o_paint_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset asserted during stroke");
        check_all_zero("midrst");
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_done", bus.o_done, 0);
            check("post_rst_busy", bus.o_busy, 0);
        end

        run_table_pass(8, 16'd10, 4'd2, 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
